pic_ack_controller: RTL

Interrupt-acknowledge and in-service controller for the 8259 PIC. It sits directly downstream of `Priority_Resolver`: it takes the resolved one-hot `interrupt_vector` and raises `int_out` to the CPU. It then runs the two-pulse 8086-mode INTA sequence, places the vector byte on the data bus, and sets and clears in-service bits. It owns the `isr` and `priority_rotate` values that feed back into the resolver, and it pulses `clear_irr` to the IRR stage.

---
 rtl/pic_ack_controller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pic_ack_controller.sv
// 8259 interrupt-acknowledge controller: 8086-mode two-pulse INTA, vector drive, ISR tracking.
// Define PIC_PRIORITY_ROTATE_EN to enable EOI-driven priority rotation.
module pic_ack_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] interrupt_vector,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_irr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

  state_e     state_q;
  logic       inta_q;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] level_q;
  logic       spurious_q;
  logic       int_out_q;
  logic [7:0] isr_q;
  logic [7:0] clear_irr_q;
  logic [7:0] data_out_q;
  logic       data_oe_q;

  logic       req_valid;
  logic [2:0] req_level;
  logic       ack_event;
  logic [7:0] ack_set;
  logic [7:0] aeoi_clr;
  logic [7:0] eoi_clr;
  logic [7:0] isr_d;
  logic [2:0] rot;
  logic       ns_found;
  logic [2:0] ns_level;
  logic [2:0] ns_idx;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // The resolver guarantees one-hot; lowest index wins if that is ever violated.
  always_comb begin
    req_valid = |interrupt_vector;
    req_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt_vector[i]) req_level = 3'(i);
    end
  end

  assign ack_event = (state_q == StIdle) && inta_fall;
  assign ack_set   = (ack_event && req_valid) ? (8'b1 << req_level) : 8'h00;

  always_comb begin
    aeoi_clr = 8'h00;
    if ((state_q == StAck2) && inta_rise && aeoi && !spurious_q) aeoi_clr[level_q] = 1'b1;
  end

  // Highest-priority in-service bit, scanning from rot upward; last hit is the winner.
  always_comb begin
    ns_found = 1'b0;
    ns_level = 3'd0;
    ns_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      ns_idx = rot + 3'(i);
      if (isr_q[ns_idx]) begin
        ns_found = 1'b1;
        ns_level = ns_idx;
      end
    end
  end

  always_comb begin
    eoi_clr = 8'h00;
    if (eoi_cmd) begin
      if (eoi_specific) eoi_clr[eoi_level] = 1'b1;
      else if (ns_found) eoi_clr[ns_level] = 1'b1;
    end
  end

  // Set is ORed last so a simultaneous set of the same bit wins over a clear.
  assign isr_d = (isr_q & ~(eoi_clr | aeoi_clr)) | ack_set;

`ifdef PIC_PRIORITY_ROTATE_EN
  logic [2:0] rot_q;
  logic [2:0] rot_d;

  always_comb begin
    rot_d = rot_q;
    if (eoi_cmd && eoi_rotate) begin
      if (eoi_specific) rot_d = eoi_level + 3'd1;
      else if (ns_found) rot_d = ns_level + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rot_q <= 3'd0;
    else          rot_q <= rot_d;
  end

  assign rot = rot_q;
`else
  logic unused_eoi_rotate;
  assign unused_eoi_rotate = eoi_rotate;
  assign rot = 3'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      inta_q      <= 1'b1;
      level_q     <= 3'd0;
      spurious_q  <= 1'b0;
      int_out_q   <= 1'b0;
      isr_q       <= 8'h00;
      clear_irr_q <= 8'h00;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
    end else begin
      inta_q      <= inta_n;
      isr_q       <= isr_d;
      clear_irr_q <= 8'h00;
      unique case (state_q)
        StIdle: begin
          int_out_q <= req_valid;
          if (inta_fall) begin
            state_q     <= StAck1;
            int_out_q   <= 1'b0;
            level_q     <= req_valid ? req_level : 3'd7;
            spurious_q  <= ~req_valid;
            clear_irr_q <= ack_set;
          end
        end
        StAck1: begin
          int_out_q <= 1'b0;
          if (inta_rise) state_q <= StGap;
        end
        StGap: begin
          int_out_q <= 1'b0;
          if (inta_fall) begin
            state_q    <= StAck2;
            data_oe_q  <= 1'b1;
            data_out_q <= {vector_base, level_q};
          end
        end
        StAck2: begin
          int_out_q  <= 1'b0;
          data_out_q <= {vector_base, level_q};
          if (inta_rise) begin
            state_q    <= StIdle;
            data_oe_q  <= 1'b0;
            data_out_q <= 8'h00;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign int_out         = int_out_q;
  assign isr             = isr_q;
  assign priority_rotate = rot;
  assign clear_irr       = clear_irr_q;
  assign data_out        = data_out_q;
  assign data_oe         = data_oe_q;

endmodule
